// File: rtl/dest_ip_tbl_ctrl.sv
// Command sequencer for the destination-IP filter table: read / write / clear-all
// commands driven as one-cycle table requests, each ack checked against a timeout.
module dest_ip_tbl_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TBL_ADDR_WIDTH     = 5,
  parameter int TBL_DEPTH          = 32,
  parameter int ACK_TIMEOUT        = 16
) (
  input  logic                          AXI_ACLK,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [TBL_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                          rsp_valid,
  output logic                          rsp_err,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic                          busy,
  output logic [31:0]                   timeout_count,
  output logic                          tbl_rd_req,
  output logic                          tbl_wr_req,
  output logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
  output logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  input  logic                          tbl_rd_ack,
  input  logic                          tbl_wr_ack
);

  localparam int WCNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0]         WAIT_MAX = WCNT_W'(ACK_TIMEOUT);
  localparam logic [TBL_ADDR_WIDTH-1:0] LAST_IDX = TBL_ADDR_WIDTH'(TBL_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, CLR_REQ, CLR_WAIT, RESP
  } state_t;

  state_t                          state_q;
  logic                            cmd_ready_q;
  logic                            rsp_valid_q;
  logic                            rsp_err_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [31:0]                     timeout_cnt_q;
  logic                            tbl_rd_req_q;
  logic                            tbl_wr_req_q;
  logic [TBL_ADDR_WIDTH-1:0]       tbl_rd_addr_q;
  logic [TBL_ADDR_WIDTH-1:0]       tbl_wr_addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   tbl_wr_data_q;
  logic [TBL_ADDR_WIDTH-1:0]       idx_q;
  logic [WCNT_W-1:0]               wait_cnt_q;
  logic                            ack_hit;

  // Only the ack that belongs to the current wait state counts.
  always_comb begin
    ack_hit = 1'b0;
    case (state_q)
      RD_WAIT:            ack_hit = tbl_rd_ack;
      WR_WAIT, CLR_WAIT:  ack_hit = tbl_wr_ack;
      default:            ack_hit = 1'b0;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      timeout_cnt_q <= '0;
      tbl_rd_req_q  <= 1'b0;
      tbl_wr_req_q  <= 1'b0;
      tbl_rd_addr_q <= '0;
      tbl_wr_addr_q <= '0;
      tbl_wr_data_q <= '0;
      idx_q         <= '0;
      wait_cnt_q    <= '0;
    end else begin
      tbl_rd_req_q <= 1'b0;
      tbl_wr_req_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            unique case (cmd_op)
              2'b01: begin
                tbl_rd_addr_q <= cmd_addr;
                tbl_rd_req_q  <= 1'b1;
                state_q       <= RD_REQ;
              end
              2'b10: begin
                tbl_wr_addr_q <= cmd_addr;
                tbl_wr_data_q <= cmd_wdata;
                tbl_wr_req_q  <= 1'b1;
                state_q       <= WR_REQ;
              end
              2'b11: begin
                idx_q         <= '0;
                tbl_wr_addr_q <= '0;
                tbl_wr_data_q <= '0;
                tbl_wr_req_q  <= 1'b1;
                state_q       <= CLR_REQ;
              end
              2'b00: begin
                rsp_valid_q <= 1'b1;
                state_q     <= RESP;
              end
            endcase
          end
        end
        RD_REQ: begin
          wait_cnt_q <= 1;
          state_q    <= RD_WAIT;
        end
        WR_REQ, CLR_REQ: begin
          wait_cnt_q <= 1;
          state_q    <= (state_q == WR_REQ) ? WR_WAIT : CLR_WAIT;
        end
        RD_WAIT, WR_WAIT, CLR_WAIT: begin
          if (ack_hit) begin
            if (state_q == RD_WAIT) rsp_rdata_q <= tbl_rd_data;
            // Clear-all sweeps by re-entering CLR_REQ until the last index acks.
            if (state_q == CLR_WAIT && idx_q != LAST_IDX) begin
              idx_q         <= idx_q + 1'b1;
              tbl_wr_addr_q <= idx_q + 1'b1;
              tbl_wr_req_q  <= 1'b1;
              state_q       <= CLR_REQ;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              state_q     <= RESP;
            end
          end else if (wait_cnt_q == WAIT_MAX) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= RESP;
            if (timeout_cnt_q != 32'hFFFF_FFFF) timeout_cnt_q <= timeout_cnt_q + 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        RESP: begin
          cmd_ready_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = (state_q != IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign timeout_count = timeout_cnt_q;
  assign tbl_rd_req    = tbl_rd_req_q;
  assign tbl_wr_req    = tbl_wr_req_q;
  assign tbl_rd_addr   = tbl_rd_addr_q;
  assign tbl_wr_addr   = tbl_wr_addr_q;
  assign tbl_wr_data   = tbl_wr_data_q;

endmodule

// File: tb/tb_dest_ip_tbl_ctrl.sv
// Directed bench for dest_ip_tbl_ctrl with a small acking table model and
// request monitors; every expectation is a hand-computed cycle or value.
module tb_dest_ip_tbl_ctrl;
  localparam int DW = 32, AW = 5, DEPTH = 32, TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_err, busy, tbl_rd_req, tbl_wr_req;
  logic [DW-1:0] rsp_rdata, tbl_wr_data, tbl_rd_data;
  logic [31:0] timeout_count;
  logic [AW-1:0] tbl_rd_addr, tbl_wr_addr;
  logic tbl_rd_ack, tbl_wr_ack;

  always #5 clk = ~clk;

  dest_ip_tbl_ctrl #(.C_S_AXI_DATA_WIDTH(DW), .TBL_ADDR_WIDTH(AW),
                     .TBL_DEPTH(DEPTH), .ACK_TIMEOUT(TO)) dut (
    .AXI_ACLK(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
    .timeout_count(timeout_count), .tbl_rd_req(tbl_rd_req), .tbl_wr_req(tbl_wr_req),
    .tbl_rd_addr(tbl_rd_addr), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .tbl_rd_data(tbl_rd_data), .tbl_rd_ack(tbl_rd_ack), .tbl_wr_ack(tbl_wr_ack)
  );

  int tests_run = 0, tests_failed = 0;
  int cyc = 0, acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Table model: registered ack one cycle after each request.
  logic [DW-1:0] mem [DEPTH];
  logic rd_ack_m = 1'b0, wr_ack_m = 1'b0, rd_ack_en = 1'b1, wr_ack_en = 1'b1;
  logic [DW-1:0] rd_data_m = '0;
  int fail_addr = -1;
  logic fill_req = 1'b0;
  logic [DW-1:0] fill_base = '0;
  logic stray_wr = 1'b0, man_rd_ack = 1'b0;
  logic [DW-1:0] man_rd_data = '0;

  always @(posedge clk) begin
    rd_ack_m <= 1'b0;
    wr_ack_m <= 1'b0;
    if (fill_req) for (int i = 0; i < DEPTH; i++) mem[i] <= fill_base + 32'(i);
    if (tbl_wr_req && wr_ack_en && int'(tbl_wr_addr) != fail_addr) begin
      mem[tbl_wr_addr] <= tbl_wr_data;
      wr_ack_m <= 1'b1;
    end
    if (tbl_rd_req && rd_ack_en) begin
      rd_data_m <= mem[tbl_rd_addr];
      rd_ack_m  <= 1'b1;
    end
  end

  assign tbl_rd_ack  = rd_ack_m | man_rd_ack;
  assign tbl_wr_ack  = wr_ack_m | stray_wr;
  assign tbl_rd_data = man_rd_ack ? man_rd_data : rd_data_m;

  // Request / response monitor.
  int wr_log_addr[$];
  logic [DW-1:0] wr_log_data[$];
  int wr_log_cyc[$];
  int rd_req_cnt = 0, rsp_cnt = 0, held_cnt = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;

  always @(posedge clk) begin
    if (tbl_wr_req === 1'b1) begin
      wr_log_addr.push_back(int'(tbl_wr_addr));
      wr_log_data.push_back(tbl_wr_data);
      wr_log_cyc.push_back(cyc);
    end
    if (tbl_rd_req === 1'b1) rd_req_cnt <= rd_req_cnt + 1;
    if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
    if ((tbl_wr_req === 1'b1 && prev_wr) || (tbl_rd_req === 1'b1 && prev_rd)) held_cnt <= held_cnt + 1;
    prev_wr <= (tbl_wr_req === 1'b1);
    prev_rd <= (tbl_rd_req === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [DW-1:0] base);
    fill_base = base;
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
  endtask

  // Waits (bounded) for cmd_ready, presents one command, returns in cycle 1.
  task automatic accept(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    acc_cyc = cyc;
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         output int rel, output logic err);
    accept(op, addr, wd);
    rel = -1;
    err = 1'bx;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid === 1'b1) begin
        rel = cyc - acc_cyc;
        err = rsp_err;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fill(32'h0000_1000);
    repeat (3) tick();
    tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
    tests_run++; if ({busy, rsp_valid, rsp_err, tbl_rd_req, tbl_wr_req} !== 5'b0) begin tests_failed++; $display("FAIL reset_ctl: got %b expected 00000", {busy, rsp_valid, rsp_err, tbl_rd_req, tbl_wr_req}); end
    tests_run++; if ({timeout_count, rsp_rdata} !== 64'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", {timeout_count, rsp_rdata}); end
    reset = 1'b0;
    tick();
    tests_run++; if ({cmd_ready, busy} !== 2'b10) begin tests_failed++; $display("FAIL reset_release: got %b expected 10", {cmd_ready, busy}); end
    $display("[TB] reset done");
  endtask

  task automatic test_write_read();
    int wl = wr_log_addr.size();
    int rb = rd_req_cnt;
    accept(2'b10, 5'd5, 32'h0A00_0001);
    tests_run++; if ({tbl_wr_req, tbl_wr_addr, tbl_wr_data} !== {1'b1, 5'd5, 32'h0A00_0001}) begin tests_failed++; $display("FAIL wr_req_c1: got %b/%0d/%h expected 1/5/0a000001", tbl_wr_req, tbl_wr_addr, tbl_wr_data); end
    tick();
    tests_run++; if ({tbl_wr_req, busy} !== 2'b01) begin tests_failed++; $display("FAIL wr_c2: got %b expected 01", {tbl_wr_req, busy}); end
    tick();
    tests_run++; if ({rsp_valid, rsp_err} !== 2'b10) begin tests_failed++; $display("FAIL wr_rsp_c3: got %b expected 10", {rsp_valid, rsp_err}); end
    tick();
    tests_run++; if ({cmd_ready, rsp_valid} !== 2'b10) begin tests_failed++; $display("FAIL wr_ready_c4: got %b expected 10", {cmd_ready, rsp_valid}); end
    tests_run++; if (wr_log_addr.size() - wl !== 1 || mem[5] !== 32'h0A00_0001) begin tests_failed++; $display("FAIL wr_table: pulses %0d mem5 %h expected 1 0a000001", wr_log_addr.size() - wl, mem[5]); end
    $display("[TB] write addr 5 data 0a000001 done");

    accept(2'b01, 5'd5, 32'h0);
    tests_run++; if ({tbl_rd_req, tbl_rd_addr} !== {1'b1, 5'd5}) begin tests_failed++; $display("FAIL rd_req_c1: got %b/%0d expected 1/5", tbl_rd_req, tbl_rd_addr); end
    tick();
    tests_run++; if (tbl_rd_req !== 1'b0) begin tests_failed++; $display("FAIL rd_req_c2: got %b expected 0", tbl_rd_req); end
    tick();
    tests_run++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0A00_0001}) begin tests_failed++; $display("FAIL rd_rsp_c3: got %b%b %h expected 10 0a000001", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    tests_run++; if (cmd_ready !== 1'b1 || rd_req_cnt - rb !== 1) begin tests_failed++; $display("FAIL rd_c4: ready %b pulses %0d expected 1 1", cmd_ready, rd_req_cnt - rb); end
    $display("[TB] read addr 5 data %h done", rsp_rdata);
  endtask

  task automatic test_rd_timeout();
    int rel;
    logic err;
    rd_ack_en = 1'b0;
    run_cmd(2'b01, 5'd5, 32'h0, rel, err);
    rd_ack_en = 1'b1;
    tests_run++; if (rel !== 1 + TO + 1 || err !== 1'b1) begin tests_failed++; $display("FAIL rd_timeout: got cycle %0d err %b expected %0d 1", rel, err, 1 + TO + 1); end
    tests_run++; if ({timeout_count, rsp_rdata} !== {32'd1, 32'h0A00_0001}) begin tests_failed++; $display("FAIL rd_timeout_state: got %0d %h expected 1 0a000001", timeout_count, rsp_rdata); end
    $display("[TB] read timeout rsp at cycle %0d err %b", rel, err);
  endtask

  task automatic test_clear_all();
    int rel;
    logic err;
    int wl = wr_log_addr.size();
    run_cmd(2'b11, 5'd0, 32'h0, rel, err);
    tests_run++; if (rel !== 65 || err !== 1'b0) begin tests_failed++; $display("FAIL clr_rsp: got cycle %0d err %b expected 65 0", rel, err); end
    tests_run++; if (wr_log_addr.size() - wl !== 32) begin tests_failed++; $display("FAIL clr_pulses: got %0d expected 32", wr_log_addr.size() - wl); end
    for (int i = 0; i < DEPTH && wl + i < wr_log_addr.size(); i++) begin
      tests_run++;
      if (wr_log_addr[wl+i] !== i || wr_log_data[wl+i] !== 32'h0 || wr_log_cyc[wl+i] - acc_cyc !== 2*i + 1) begin
        tests_failed++;
        $display("FAIL clr_entry%0d: got addr %0d data %h cycle %0d expected %0d 0 %0d", i, wr_log_addr[wl+i], wr_log_data[wl+i], wr_log_cyc[wl+i] - acc_cyc, i, 2*i + 1);
      end
    end
    run_cmd(2'b01, 5'd17, 32'h0, rel, err);
    tests_run++; if ({err, rsp_rdata} !== {1'b0, 32'h0}) begin tests_failed++; $display("FAIL clr_readback: got err %b data %h expected 0 0", err, rsp_rdata); end
    $display("[TB] clear-all rsp at cycle 65 checked, readback addr 17 = %h", rsp_rdata);
  endtask

  task automatic test_clear_fail();
    int rel, bad_kept, bad_zero;
    logic err;
    int wl;
    logic [31:0] tc0;
    fill(32'hC0DE_0000);
    wl = wr_log_addr.size();
    tc0 = timeout_count;
    fail_addr = 10;
    run_cmd(2'b11, 5'd0, 32'h0, rel, err);
    fail_addr = -1;
    tests_run++; if (rel !== 2*10 + 1 + TO + 1 || err !== 1'b1) begin tests_failed++; $display("FAIL clrf_rsp: got cycle %0d err %b expected %0d 1", rel, err, 2*10 + 1 + TO + 1); end
    tests_run++; if (wr_log_addr.size() - wl !== 11) begin tests_failed++; $display("FAIL clrf_pulses: got %0d expected 11", wr_log_addr.size() - wl); end
    tests_run++; if (timeout_count !== tc0 + 32'd1) begin tests_failed++; $display("FAIL clrf_tocnt: got %0d expected %0d", timeout_count, tc0 + 32'd1); end
    bad_kept = 0;
    bad_zero = 0;
    for (int i = 10; i < DEPTH; i++) if (mem[i] !== 32'hC0DE_0000 + 32'(i)) bad_kept++;
    for (int i = 0; i < 10; i++) if (mem[i] !== 32'h0) bad_zero++;
    tests_run++; if (bad_kept !== 0) begin tests_failed++; $display("FAIL clrf_kept: got %0d changed entries expected 0", bad_kept); end
    tests_run++; if (bad_zero !== 0) begin tests_failed++; $display("FAIL clrf_zeroed: got %0d nonzero entries expected 0", bad_zero); end
    $display("[TB] clear-all with ack failure at 10: rsp cycle %0d err %b", rel, err);
  endtask

  task automatic test_reset_mid();
    int rel;
    logic err;
    int wl, rc, n;
    fill(32'h5A00_0000);
    wl = wr_log_addr.size();
    rc = rsp_cnt;
    accept(2'b11, 5'd0, 32'h0);
    n = 0;
    while (cyc - acc_cyc < 20 && n < 40) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    tests_run++; if (wr_log_addr.size() - wl !== 10) begin tests_failed++; $display("FAIL mid_pulses: got %0d expected 10", wr_log_addr.size() - wl); end
    tests_run++; if ({busy, cmd_ready} !== 2'b01 || rsp_cnt !== rc) begin tests_failed++; $display("FAIL mid_state: busy/ready %b rsp %0d expected 01 %0d", {busy, cmd_ready}, rsp_cnt, rc); end
    tests_run++; if ({timeout_count, mem[10]} !== {32'h0, 32'h5A00_000A}) begin tests_failed++; $display("FAIL mid_table: got %0d %h expected 0 5a00000a", timeout_count, mem[10]); end
    run_cmd(2'b10, 5'd3, 32'h0000_0055, rel, err);
    tick();
    tests_run++; if (rel !== 3 || err !== 1'b0 || mem[3] !== 32'h55) begin tests_failed++; $display("FAIL mid_next: got cycle %0d err %b mem3 %h expected 3 0 00000055", rel, err, mem[3]); end
    $display("[TB] reset during clear-all, next write rsp cycle %0d", rel);
  endtask

  task automatic test_back_to_back();
    int rb, n;
    logic ready_seen;
    rb = rd_req_cnt;
    rd_ack_en = 1'b0;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    acc_cyc = cyc;
    cmd_op = 2'b01; cmd_addr = 5'd7; cmd_valid = 1'b1;
    tick();
    ready_seen = cmd_ready;
    tick();
    ready_seen |= cmd_ready;
    tick();
    ready_seen |= cmd_ready;
    stray_wr = 1'b1;
    tick();
    stray_wr = 1'b0;
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL stray_ack: got rsp_valid %b expected 0", rsp_valid); end
    tick();
    man_rd_data = 32'h1234_5678;
    man_rd_ack = 1'b1;
    tick();
    man_rd_ack = 1'b0;
    ready_seen |= cmd_ready;
    tests_run++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h1234_5678}) begin tests_failed++; $display("FAIL b2b_rsp_c6: got %b%b %h expected 10 12345678", rsp_valid, rsp_err, rsp_rdata); end
    tests_run++; if (ready_seen !== 1'b0) begin tests_failed++; $display("FAIL b2b_holdoff: got ready %b expected 0", ready_seen); end
    tick();
    tests_run++; if (cmd_ready !== 1'b1 || rd_req_cnt - rb !== 1) begin tests_failed++; $display("FAIL b2b_c7: ready %b pulses %0d expected 1 1", cmd_ready, rd_req_cnt - rb); end
    cmd_op = 2'b00;
    acc_cyc = cyc;
    tick();
    cmd_valid = 1'b0;
    tests_run++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h1234_5678} || cyc - acc_cyc !== 1) begin tests_failed++; $display("FAIL nop_rsp: got %b%b %h at %0d expected 10 12345678 at 1", rsp_valid, rsp_err, rsp_rdata, cyc - acc_cyc); end
    rd_ack_en = 1'b1;
    tick();
    $display("[TB] held read with stray wr_ack then nop done");
  endtask

  task automatic test_saturate();
    int rel;
    logic err;
    force dut.timeout_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.timeout_cnt_q;
    tick();
    tests_run++; if (timeout_count !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL sat_preload: got %h expected ffffffff", timeout_count); end
    rd_ack_en = 1'b0;
    run_cmd(2'b01, 5'd2, 32'h0, rel, err);
    rd_ack_en = 1'b1;
    tick();
    tests_run++; if (err !== 1'b1 || timeout_count !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL sat_count: got err %b count %h expected 1 ffffffff", err, timeout_count); end
    $display("[TB] saturating timeout count %h", timeout_count);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rd_timeout();
    test_clear_all();
    test_clear_fail();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    tests_run++; if (held_cnt !== 0) begin tests_failed++; $display("FAIL req_held: got %0d held cycles expected 0", held_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
